// File: rtl/pipe_control_pkg.sv
// Shared rv32i control encodings: opcodes, func codes, ALU/adder/writeback/forward selects and
// the ID-stage control bundle produced by the decoder.
package pipe_control_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011, F3_XOR = 3'b100, F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR = 3'b110, F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000, F3_BNE = 3'b001, F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101, F3_BLTU = 3'b110, F3_BGEU = 3'b111;
    localparam logic [6:0] F7_BASE = 7'h00, F7_ALT = 7'h20;

    localparam logic [3:0] ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_SLL = 4'h2, ALU_SLT = 4'h3;
    localparam logic [3:0] ALU_SLTU = 4'h4, ALU_XOR = 4'h5, ALU_SRL = 4'h6, ALU_SRA = 4'h7;
    localparam logic [3:0] ALU_OR = 4'h8, ALU_AND = 4'h9, ALU_NOP = 4'hF;

    localparam logic [1:0] SEC_AS_NONE = 2'd0, SEC_AS_LUI = 2'd1;
    localparam logic [1:0] SEC_AS_AUIPC = 2'd2, SEC_AS_JALR = 2'd3;

    localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2, WB_SEC = 2'd3;
    localparam logic [1:0] FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10;

    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4, IMM_NONE = 3'b111;

    typedef struct packed {
        logic       legal;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       is_branch;
        logic       is_jump;
        logic       alu_src;
        logic [3:0] alu_ctrl;
        logic [1:0] sec_src;
        logic [1:0] wb_src;
        logic [2:0] imm_src;
    } id_ctrl_t;

    localparam int unsigned ID_CTRL_W = $bits(id_ctrl_t);

    // Register ops use func7 to pick SUB; immediate ops only use it for SRAI.
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt,
                                               input logic is_reg);
        case (f3)
            F3_ADD_SUB: return (is_reg && alt) ? ALU_SUB : ALU_ADD;
            F3_SLL:     return ALU_SLL;
            F3_SLT:     return ALU_SLT;
            F3_SLTU:    return ALU_SLTU;
            F3_XOR:     return ALU_XOR;
            F3_SRL_SRA: return alt ? ALU_SRA : ALU_SRL;
            F3_OR:      return ALU_OR;
            default:    return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/pipe_control_decode.sv
// Combinational rv32i decoder: opcode/func3/func7 to the ID-stage control bundle.
module ctrl_decode
    import pipe_control_pkg::*;
(
    input  logic [6:0]           i_opcode,
    input  logic [2:0]           i_func3,
    input  logic [6:0]           i_func7,
    output logic [ID_CTRL_W-1:0] o_ctrl
);

    id_ctrl_t w_ctrl;
    logic     w_alt;

    assign w_alt  = (i_func7 == F7_ALT);
    assign o_ctrl = w_ctrl;

    always_comb begin
        w_ctrl          = '0;
        w_ctrl.legal    = 1'b1;
        w_ctrl.alu_ctrl = ALU_NOP;
        w_ctrl.sec_src  = SEC_AS_NONE;
        w_ctrl.wb_src   = WB_ALU;
        w_ctrl.imm_src  = IMM_NONE;
        case (i_opcode)
            OPC_LUI, OPC_AUIPC: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.wb_src    = WB_SEC;
                w_ctrl.sec_src   = (i_opcode == OPC_LUI) ? SEC_AS_LUI : SEC_AS_AUIPC;
                w_ctrl.imm_src   = IMM_U;
            end
            OPC_JAL, OPC_JALR: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.wb_src    = WB_PC4;
                w_ctrl.is_jump   = 1'b1;
                w_ctrl.alu_ctrl  = ALU_ADD;
                if (i_opcode == OPC_JALR) begin
                    w_ctrl.uses_rs1 = 1'b1;
                    w_ctrl.alu_src  = 1'b1;
                    w_ctrl.sec_src  = SEC_AS_JALR;
                    w_ctrl.imm_src  = IMM_I;
                end else begin
                    w_ctrl.imm_src  = IMM_J;
                end
            end
            OPC_BRANCH: begin
                w_ctrl.uses_rs1  = 1'b1;
                w_ctrl.uses_rs2  = 1'b1;
                w_ctrl.is_branch = 1'b1;
                w_ctrl.imm_src   = IMM_B;
                case (i_func3)
                    F3_BEQ, F3_BNE:   w_ctrl.alu_ctrl = ALU_SUB;
                    F3_BLT, F3_BGE:   w_ctrl.alu_ctrl = ALU_SLT;
                    F3_BLTU, F3_BGEU: w_ctrl.alu_ctrl = ALU_SLTU;
                    default: begin
                        w_ctrl.legal     = 1'b0;
                        w_ctrl.is_branch = 1'b0;
                    end
                endcase
            end
            OPC_LOAD: begin
                w_ctrl.uses_rs1  = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.wb_src    = WB_MEM;
                w_ctrl.alu_ctrl  = ALU_ADD;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.imm_src   = IMM_I;
            end
            OPC_STORE: begin
                w_ctrl.uses_rs1  = 1'b1;
                w_ctrl.uses_rs2  = 1'b1;
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_ctrl  = ALU_ADD;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.imm_src   = IMM_S;
            end
            OPC_OP_IMM: begin
                w_ctrl.uses_rs1  = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.imm_src   = IMM_I;
                w_ctrl.alu_ctrl  = alu_from_f3(i_func3, w_alt, 1'b0);
                // Shift immediates with a bad func7 still flow down the pipe but never write.
                w_ctrl.reg_write = !((i_func3 == F3_SLL && i_func7 != F7_BASE) ||
                                     (i_func3 == F3_SRL_SRA && i_func7 != F7_BASE && !w_alt));
            end
            OPC_OP: begin
                w_ctrl.uses_rs1  = 1'b1;
                w_ctrl.uses_rs2  = 1'b1;
                w_ctrl.alu_ctrl  = alu_from_f3(i_func3, w_alt, 1'b1);
                w_ctrl.reg_write = (i_func7 == F7_BASE) ||
                                   (w_alt && (i_func3 == F3_ADD_SUB || i_func3 == F3_SRL_SRA));
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
            end
            default: w_ctrl.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipe_control.sv
// Pipelined rv32i control: ID decode, registered EX/MEM/WB control, load-use stall,
// branch/jump redirect with flush, and EX operand forwarding selects.
module pipe_control
    import pipe_control_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALU_CTRL_W = 4,
    parameter bit          FWD_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_id_valid,
    input  logic [6:0]            i_opcode,
    input  logic [2:0]            i_func3,
    input  logic [6:0]            i_func7,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_ex_alu_zero,
    input  logic                  i_ex_alu_lsb,
    output logic [2:0]            o_id_imm_src,
    output logic                  o_id_illegal,
    output logic                  o_ex_valid,
    output logic                  o_ex_alu_src,
    output logic [ALU_CTRL_W-1:0] o_ex_alu_ctrl,
    output logic [1:0]            o_ex_second_add_src,
    output logic                  o_mem_valid,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic                  o_wb_valid,
    output logic                  o_wb_reg_write,
    output logic [1:0]            o_wb_src,
    output logic [REG_ADDR_W-1:0] o_wb_rd,
    output logic [1:0]            o_fwd_a,
    output logic [1:0]            o_fwd_b,
    output logic                  o_pc_en,
    output logic                  o_if_id_en,
    output logic                  o_redirect,
    output logic                  o_if_id_flush
);

    id_ctrl_t w_dec;

    ctrl_decode u_decode (
        .i_opcode (i_opcode),
        .i_func3  (i_func3),
        .i_func7  (i_func7),
        .o_ctrl   (w_dec)
    );

    logic                  r_ex_valid, r_ex_reg_write, r_ex_mem_read, r_ex_mem_write;
    logic                  r_ex_alu_src, r_ex_is_branch, r_ex_is_jump;
    logic [ALU_CTRL_W-1:0] r_ex_alu_ctrl;
    logic [1:0]            r_ex_sec, r_ex_wb_src;
    logic [2:0]            r_ex_func3;
    logic [REG_ADDR_W-1:0] r_ex_rd, r_ex_rs1, r_ex_rs2;
    logic                  r_mem_valid, r_mem_reg_write, r_mem_read, r_mem_write;
    logic [1:0]            r_mem_wb_src;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic                  r_wb_valid, r_wb_reg_write;
    logic [1:0]            r_wb_src;
    logic [REG_ADDR_W-1:0] r_wb_rd;

    logic w_id_live, w_rs1_use, w_rs2_use, w_ex_hit, w_mem_hit;
    logic w_br_taken, w_redirect, w_load_use, w_raw_stall, w_stall, w_ex_bubble;
    logic w_mem_fwd_ok, w_wb_fwd_ok;

    assign w_id_live = i_id_valid & w_dec.legal;
    assign w_rs1_use = w_id_live & w_dec.uses_rs1;
    assign w_rs2_use = w_id_live & w_dec.uses_rs2;
    assign w_ex_hit  = (w_rs1_use & (r_ex_rd == i_id_rs1)) | (w_rs2_use & (r_ex_rd == i_id_rs2));
    assign w_mem_hit = (w_rs1_use & (r_mem_rd == i_id_rs1)) | (w_rs2_use & (r_mem_rd == i_id_rs2));

    always_comb begin
        case (r_ex_func3)
            F3_BEQ:          w_br_taken = i_ex_alu_zero;
            F3_BNE:          w_br_taken = ~i_ex_alu_zero;
            F3_BLT, F3_BLTU: w_br_taken = i_ex_alu_lsb;
            F3_BGE, F3_BGEU: w_br_taken = ~i_ex_alu_lsb;
            default:         w_br_taken = 1'b0;
        endcase
    end

    assign w_redirect  = r_ex_valid & (r_ex_is_jump | (r_ex_is_branch & w_br_taken));
    assign w_load_use  = r_ex_valid & r_ex_mem_read & (r_ex_rd != '0) & w_ex_hit;
    // Without forwarding every in-flight producer in EX or MEM is a hazard.
    assign w_raw_stall = ~FWD_EN &
                         ((r_ex_valid & r_ex_reg_write & (r_ex_rd != '0) & w_ex_hit) |
                          (r_mem_valid & r_mem_reg_write & (r_mem_rd != '0) & w_mem_hit));
    assign w_stall     = (w_load_use | w_raw_stall) & ~w_redirect;
    assign w_ex_bubble = w_stall | w_redirect | ~w_id_live;

    assign w_mem_fwd_ok = r_mem_valid & r_mem_reg_write & (r_mem_rd != '0) & ~r_mem_read;
    assign w_wb_fwd_ok  = r_wb_valid & r_wb_reg_write & (r_wb_rd != '0);

    always_comb begin
        o_fwd_a = FWD_RF;
        o_fwd_b = FWD_RF;
        if (FWD_EN) begin
            if (w_mem_fwd_ok && r_mem_rd == r_ex_rs1)     o_fwd_a = FWD_MEM;
            else if (w_wb_fwd_ok && r_wb_rd == r_ex_rs1)  o_fwd_a = FWD_WB;
            if (w_mem_fwd_ok && r_mem_rd == r_ex_rs2)     o_fwd_b = FWD_MEM;
            else if (w_wb_fwd_ok && r_wb_rd == r_ex_rs2)  o_fwd_b = FWD_WB;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ex_valid <= 1'b0; r_ex_reg_write <= 1'b0; r_ex_mem_read <= 1'b0;
            r_ex_mem_write <= 1'b0; r_ex_alu_src <= 1'b0; r_ex_is_branch <= 1'b0;
            r_ex_is_jump <= 1'b0; r_ex_alu_ctrl <= ALU_CTRL_W'(ALU_NOP);
            r_ex_sec <= SEC_AS_NONE; r_ex_wb_src <= WB_ALU; r_ex_func3 <= '0;
            r_ex_rd <= '0; r_ex_rs1 <= '0; r_ex_rs2 <= '0;
            r_mem_valid <= 1'b0; r_mem_reg_write <= 1'b0; r_mem_read <= 1'b0;
            r_mem_write <= 1'b0; r_mem_wb_src <= WB_ALU; r_mem_rd <= '0;
            r_wb_valid <= 1'b0; r_wb_reg_write <= 1'b0; r_wb_src <= WB_ALU; r_wb_rd <= '0;
        end else begin
            if (w_ex_bubble) begin
                r_ex_valid <= 1'b0; r_ex_reg_write <= 1'b0; r_ex_mem_read <= 1'b0;
                r_ex_mem_write <= 1'b0; r_ex_alu_src <= 1'b0; r_ex_is_branch <= 1'b0;
                r_ex_is_jump <= 1'b0; r_ex_alu_ctrl <= ALU_CTRL_W'(ALU_NOP);
                r_ex_sec <= SEC_AS_NONE; r_ex_wb_src <= WB_ALU; r_ex_func3 <= '0;
                r_ex_rd <= '0; r_ex_rs1 <= '0; r_ex_rs2 <= '0;
            end else begin
                r_ex_valid     <= 1'b1;
                r_ex_reg_write <= w_dec.reg_write;
                r_ex_mem_read  <= w_dec.mem_read;
                r_ex_mem_write <= w_dec.mem_write;
                r_ex_alu_src   <= w_dec.alu_src;
                r_ex_is_branch <= w_dec.is_branch;
                r_ex_is_jump   <= w_dec.is_jump;
                r_ex_alu_ctrl  <= ALU_CTRL_W'(w_dec.alu_ctrl);
                r_ex_sec       <= w_dec.sec_src;
                r_ex_wb_src    <= w_dec.wb_src;
                r_ex_func3     <= i_func3;
                r_ex_rd        <= i_id_rd;
                // Unread source fields are zeroed so they can never match a producer.
                r_ex_rs1       <= w_dec.uses_rs1 ? i_id_rs1 : '0;
                r_ex_rs2       <= w_dec.uses_rs2 ? i_id_rs2 : '0;
            end
            r_mem_valid     <= r_ex_valid;
            r_mem_reg_write <= r_ex_reg_write;
            r_mem_read      <= r_ex_mem_read;
            r_mem_write     <= r_ex_mem_write;
            r_mem_wb_src    <= r_ex_wb_src;
            r_mem_rd        <= r_ex_rd;
            r_wb_valid      <= r_mem_valid;
            r_wb_reg_write  <= r_mem_reg_write;
            r_wb_src        <= r_mem_wb_src;
            r_wb_rd         <= r_mem_rd;
        end
    end

    assign o_id_imm_src        = i_id_valid ? w_dec.imm_src : IMM_NONE;
    assign o_id_illegal        = i_id_valid & ~w_dec.legal;
    assign o_ex_valid          = r_ex_valid;
    assign o_ex_alu_src        = r_ex_alu_src;
    assign o_ex_alu_ctrl       = r_ex_alu_ctrl;
    assign o_ex_second_add_src = r_ex_sec;
    assign o_mem_valid         = r_mem_valid;
    assign o_mem_read          = r_mem_read;
    assign o_mem_write         = r_mem_write;
    assign o_wb_valid          = r_wb_valid;
    assign o_wb_reg_write      = r_wb_reg_write;
    assign o_wb_src            = r_wb_src;
    assign o_wb_rd             = r_wb_rd;
    assign o_pc_en             = ~w_stall;
    assign o_if_id_en          = ~w_stall;
    assign o_redirect          = w_redirect;
    assign o_if_id_flush       = w_redirect;

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: forwarding, load-use stall, redirect/flush, decode corners,
// plus a no-forwarding instance for RAW stall and redirect-over-stall priority.
module tb_pipe_control;

    localparam logic [6:0] OP = 7'h33, OPIMM = 7'h13, LOAD = 7'h03, BR = 7'h63;
    localparam logic [6:0] JAL = 7'h6F, LUI = 7'h37, BAD = 7'h7F;

    logic clk = 1'b0;
    logic rst, id_valid, alu_zero, alu_lsb;
    logic [6:0] opcode, func7;
    logic [2:0] func3;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic [2:0] imm_src, nf_imm_src;
    logic       illegal, ex_valid, alu_src, mem_valid, mem_read, mem_write, wb_valid;
    logic       wb_reg_write, pc_en, if_id_en, redirect, flush;
    logic [3:0] alu_ctrl, nf_alu_ctrl;
    logic [1:0] sec, wb_src, fwd_a, fwd_b;
    logic [4:0] wb_rd, nf_wb_rd;
    logic       nf_illegal, nf_ex_valid, nf_alu_src, nf_mem_valid, nf_mem_read, nf_mem_write;
    logic       nf_wb_valid, nf_wb_reg_write, nf_pc_en, nf_if_id_en, nf_redirect, nf_flush;
    logic [1:0] nf_sec, nf_wb_src, nf_fwd_a, nf_fwd_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_control #(.REG_ADDR_W(5), .ALU_CTRL_W(4), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .i_id_valid(id_valid), .i_opcode(opcode), .i_func3(func3),
        .i_func7(func7), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd),
        .i_ex_alu_zero(alu_zero), .i_ex_alu_lsb(alu_lsb), .o_id_imm_src(imm_src),
        .o_id_illegal(illegal), .o_ex_valid(ex_valid), .o_ex_alu_src(alu_src),
        .o_ex_alu_ctrl(alu_ctrl), .o_ex_second_add_src(sec), .o_mem_valid(mem_valid),
        .o_mem_read(mem_read), .o_mem_write(mem_write), .o_wb_valid(wb_valid),
        .o_wb_reg_write(wb_reg_write), .o_wb_src(wb_src), .o_wb_rd(wb_rd), .o_fwd_a(fwd_a),
        .o_fwd_b(fwd_b), .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_redirect(redirect),
        .o_if_id_flush(flush)
    );

    pipe_control #(.REG_ADDR_W(5), .ALU_CTRL_W(4), .FWD_EN(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .i_id_valid(id_valid), .i_opcode(opcode), .i_func3(func3),
        .i_func7(func7), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd),
        .i_ex_alu_zero(alu_zero), .i_ex_alu_lsb(alu_lsb), .o_id_imm_src(nf_imm_src),
        .o_id_illegal(nf_illegal), .o_ex_valid(nf_ex_valid), .o_ex_alu_src(nf_alu_src),
        .o_ex_alu_ctrl(nf_alu_ctrl), .o_ex_second_add_src(nf_sec), .o_mem_valid(nf_mem_valid),
        .o_mem_read(nf_mem_read), .o_mem_write(nf_mem_write), .o_wb_valid(nf_wb_valid),
        .o_wb_reg_write(nf_wb_reg_write), .o_wb_src(nf_wb_src), .o_wb_rd(nf_wb_rd),
        .o_fwd_a(nf_fwd_a), .o_fwd_b(nf_fwd_b), .o_pc_en(nf_pc_en), .o_if_id_en(nf_if_id_en),
        .o_redirect(nf_redirect), .o_if_id_flush(nf_flush)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d);
        id_valid = v; opcode = op; func3 = f3; func7 = f7;
        id_rs1 = s1; id_rs2 = s2; id_rd = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0);
        repeat (n) tick();
    endtask

    initial begin
        rst = 1'b0; alu_zero = 1'b0; alu_lsb = 1'b0;
        drive(1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0);
        tick(); tick(); settle();
        check_val("rst_ex_valid", 32'(ex_valid), 0);
        check_val("rst_mem_valid", 32'(mem_valid), 0);
        check_val("rst_wb_valid", 32'(wb_valid), 0);
        check_val("rst_pc_en", 32'(pc_en), 1);
        check_val("rst_if_id_en", 32'(if_id_en), 1);
        check_val("rst_alu_nop", 32'(alu_ctrl), 32'hF);
        check_val("rst_redirect", 32'(redirect), 0);
        check_val("rst_flush", 32'(flush), 0);
        check_val("rst_imm_src", 32'(imm_src), 7);
        check_val("rst_sec", 32'(sec), 0);
        check_val("rst_wb_src", 32'(wb_src), 0);
        check_val("rst_wb_rd", 32'(wb_rd), 0);
        check_val("rst_fwd", 32'({fwd_a, fwd_b}), 0);
        rst = 1'b1;
        tick();

        // add x3,x1,x2 ; sub x4,x3,x1
        drive(1'b1, OP, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3); tick();
        drive(1'b1, OP, 3'd0, 7'h20, 5'd3, 5'd1, 5'd4); settle();
        check_val("fwd_pc_en", 32'(pc_en), 1);
        check_val("nf_raw_stall", 32'(nf_pc_en), 0);
        tick();
        drive(1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0); settle();
        check_val("sub_fwd_a", 32'(fwd_a), 1);
        check_val("sub_fwd_b", 32'(fwd_b), 0);
        check_val("sub_alu", 32'(alu_ctrl), 1);
        check_val("nf_fwd_a", 32'(nf_fwd_a), 0);
        tick(); settle();
        check_val("add_wb_rd", 32'(wb_rd), 3);
        check_val("add_wb_we", 32'(wb_reg_write), 1);
        idle(4);

        // lw x5,0(x1) ; add x6,x5,x2
        drive(1'b1, LOAD, 3'd2, 7'h00, 5'd1, 5'd0, 5'd5); tick();
        drive(1'b1, OP, 3'd0, 7'h00, 5'd5, 5'd2, 5'd6); settle();
        check_val("lu_pc_en", 32'(pc_en), 0);
        check_val("lu_if_id_en", 32'(if_id_en), 0);
        tick(); settle();
        check_val("lu_bubble", 32'(ex_valid), 0);
        check_val("lu_release", 32'(pc_en), 1);
        tick();
        drive(1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0); settle();
        check_val("lu_add_valid", 32'(ex_valid), 1);
        check_val("lu_fwd_a", 32'(fwd_a), 2);
        check_val("lu_fwd_b", 32'(fwd_b), 0);
        idle(4);

        // beq x1,x1 taken
        drive(1'b1, BR, 3'd0, 7'h00, 5'd1, 5'd1, 5'd0); tick();
        alu_zero = 1'b1;
        drive(1'b1, OPIMM, 3'd0, 7'h00, 5'd1, 5'd0, 5'd7); settle();
        check_val("beq_redirect", 32'(redirect), 1);
        check_val("beq_flush", 32'(flush), 1);
        check_val("beq_pc_en", 32'(pc_en), 1);
        tick();
        alu_zero = 1'b0;
        drive(1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0); settle();
        check_val("beq_one_cycle", 32'(redirect), 0);
        check_val("beq_killed_ex", 32'(ex_valid), 0);
        tick(); settle();
        check_val("beq_killed_mem", 32'(mem_valid), 0);
        idle(3);

        // beq not taken
        drive(1'b1, BR, 3'd0, 7'h00, 5'd1, 5'd1, 5'd0); tick();
        drive(1'b1, OPIMM, 3'd0, 7'h00, 5'd1, 5'd0, 5'd7); settle();
        check_val("beq_nt_redirect", 32'(redirect), 0);
        tick();
        drive(1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0); settle();
        check_val("beq_nt_ex", 32'(ex_valid), 1);
        tick(); settle();
        check_val("beq_nt_mem", 32'(mem_valid), 1);
        idle(3);

        // blt taken on lsb=1, bge not taken on lsb=1
        drive(1'b1, BR, 3'd4, 7'h00, 5'd1, 5'd2, 5'd0); tick();
        alu_lsb = 1'b1; drive(1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0); settle();
        check_val("blt_redirect", 32'(redirect), 1);
        alu_lsb = 1'b0; idle(3);
        drive(1'b1, BR, 3'd5, 7'h00, 5'd1, 5'd2, 5'd0); tick();
        alu_lsb = 1'b1; drive(1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0); settle();
        check_val("bge_redirect", 32'(redirect), 0);
        alu_lsb = 1'b0; idle(3);

        // jal x5 in EX with dependent add in ID: redirect wins over stall
        drive(1'b1, JAL, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5); settle();
        check_val("jal_imm_src", 32'(imm_src), 4);
        tick();
        drive(1'b1, OP, 3'd0, 7'h00, 5'd5, 5'd2, 5'd6); settle();
        check_val("jal_redirect", 32'(redirect), 1);
        check_val("jal_pc_en", 32'(pc_en), 1);
        check_val("nf_prio_redirect", 32'(nf_redirect), 1);
        check_val("nf_prio_pc_en", 32'(nf_pc_en), 1);
        tick();
        drive(1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0); settle();
        check_val("jal_bubble", 32'(ex_valid), 0);
        idle(3);

        // slli with func7=0x20 never writes back
        drive(1'b1, OPIMM, 3'd1, 7'h20, 5'd1, 5'd0, 5'd8); settle();
        check_val("slli_legal", 32'(illegal), 0);
        tick();
        idle(2); settle();
        check_val("slli_wb_valid", 32'(wb_valid), 1);
        check_val("slli_wb_we", 32'(wb_reg_write), 0);
        check_val("slli_wb_rd", 32'(wb_rd), 8);
        idle(2);

        // unknown opcode
        drive(1'b1, BAD, 3'd0, 7'h00, 5'd1, 5'd2, 5'd9); settle();
        check_val("bad_illegal", 32'(illegal), 1);
        check_val("bad_imm_src", 32'(imm_src), 7);
        tick();
        drive(1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0); settle();
        check_val("bad_bubble", 32'(ex_valid), 0);
        idle(2);

        // addi x0 producer, consumer reads x0
        drive(1'b1, OPIMM, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0); tick();
        drive(1'b1, OP, 3'd0, 7'h00, 5'd0, 5'd2, 5'd9); tick();
        drive(1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0); settle();
        check_val("x0_ex_valid", 32'(ex_valid), 1);
        check_val("x0_fwd_a", 32'(fwd_a), 0);
        idle(3);

        // lui
        drive(1'b1, LUI, 3'd0, 7'h00, 5'd0, 5'd0, 5'd10); settle();
        check_val("lui_imm_src", 32'(imm_src), 3);
        tick();
        drive(1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0); settle();
        check_val("lui_sec", 32'(sec), 1);
        idle(3);

        // reset while an instruction is in EX drops it
        drive(1'b1, OP, 3'd0, 7'h00, 5'd1, 5'd2, 5'd11); tick();
        rst = 1'b0;
        drive(1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0);
        tick(); settle();
        check_val("rst_drop_mem", 32'(mem_valid), 0);
        check_val("rst_drop_ex", 32'(ex_valid), 0);
        rst = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
